// File: rtl/fft_sched_pkg.sv
// Shared types and default timing constants for the FFT stage-3/stage-4 scheduler.
package fft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int unsigned DEF_D3    = 24;
    localparam int unsigned DEF_D4    = 28;
    localparam int unsigned DEF_HALF3 = 8;
    localparam int unsigned DEF_HALF4 = 4;
    localparam int unsigned DEF_N     = 32;

endpackage

// File: rtl/fft_sw_toggle.sv
// Butterfly switch toggler plus coefficient address counter for one FFT stage.
// en is the enable of the upcoming cycle, so ctrl/addr line up with the stage's registered enable.
module fft_sw_toggle #(
    parameter  int unsigned HALF = 8,
    parameter  int unsigned N    = 32,
    localparam int unsigned AW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          ctrl,
    output logic [AW-1:0] addr
);

    localparam int unsigned PW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [PW-1:0] phase;
    logic          on;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on    <= 1'b0;
            phase <= '0;
            ctrl  <= 1'b0;
            addr  <= '0;
        end else begin
            on <= en;
            if (!en || !on) begin
                // Disabled, or first enabled cycle: both present zero.
                phase <= '0;
                ctrl  <= 1'b0;
                addr  <= '0;
            end else begin
                addr <= (addr == AW'(N - 1)) ? '0 : addr + 1'b1;
                if (phase == PW'(HALF - 1)) begin
                    phase <= '0;
                    ctrl  <= ~ctrl;
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fft_stage_sched.sv
// Frame scheduler for FFT stages 3 and 4: IDLE/FILL/RUN/DRAIN sequencing of stage enables,
// butterfly switch selects and coefficient addresses, all from registers.
module fft_stage_sched
    import fft_sched_pkg::*;
#(
    parameter  int unsigned D3    = DEF_D3,
    parameter  int unsigned D4    = DEF_D4,
    parameter  int unsigned HALF3 = DEF_HALF3,
    parameter  int unsigned HALF4 = DEF_HALF4,
    parameter  int unsigned N     = DEF_N,
    localparam int unsigned AW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    output logic          stage3_en,
    output logic          stage4_en,
    output logic          ctrl_bf3,
    output logic          ctrl_bf4,
    output logic [AW-1:0] coeff3_addr,
    output logic [AW-1:0] coeff4_addr,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned CW = $clog2(D4 + 1);

    // cnt holds k-1 in the k-th cycle after start, so enables fire one count early.
    localparam logic [CW-1:0] FIRE3 = CW'((D3 >= 2) ? D3 - 2 : 0);
    localparam logic [CW-1:0] FIRE4 = CW'(D4 - 2);
    localparam logic [CW-1:0] LAST  = CW'(D4 - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          en3_nxt;
    logic          en4_nxt;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        en3_nxt = 1'b0;
        en4_nxt = 1'b0;
        unique case (state)
            IDLE: en3_nxt = start && (D3 == 1);
            FILL: begin
                if (!stop) begin
                    en3_nxt = stage3_en || (cnt == FIRE3);
                    en4_nxt = (cnt == FIRE4);
                end
            end
            RUN: begin
                en3_nxt = 1'b1;
                en4_nxt = 1'b1;
            end
            DRAIN: begin
                en3_nxt = (cnt != LAST);
                en4_nxt = (cnt != LAST);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            stage3_en  <= 1'b0;
            stage4_en  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            stage3_en  <= en3_nxt;
            stage4_en  <= en4_nxt;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (stop) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == FIRE4) state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end
                end
                DRAIN: begin
                    if (cnt == LAST) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    fft_sw_toggle #(.HALF(HALF3), .N(N)) u_sw3 (
        .clk  (clk),
        .rst  (rst),
        .en   (en3_nxt),
        .ctrl (ctrl_bf3),
        .addr (coeff3_addr)
    );

    fft_sw_toggle #(.HALF(HALF4), .N(N)) u_sw4 (
        .clk  (clk),
        .rst  (rst),
        .en   (en4_nxt),
        .ctrl (ctrl_bf4),
        .addr (coeff4_addr)
    );

endmodule

// File: tb/tb_fft_stage_sched.sv
// Self-checking bench for fft_stage_sched: directed frames plus random start/stop traffic,
// compared cycle by cycle against a frame-time reference model.
module tb_fft_stage_sched;

    localparam int D3    = 24;
    localparam int D4    = 28;
    localparam int HALF3 = 8;
    localparam int HALF4 = 4;
    localparam int N     = 32;
    localparam int AW    = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          stage3_en;
    logic          stage4_en;
    logic          ctrl_bf3;
    logic          ctrl_bf4;
    logic [AW-1:0] coeff3_addr;
    logic [AW-1:0] coeff4_addr;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    fft_stage_sched #(
        .D3(D3), .D4(D4), .HALF3(HALF3), .HALF4(HALF4), .N(N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .stage3_en   (stage3_en),
        .stage4_en   (stage4_en),
        .ctrl_bf3    (ctrl_bf3),
        .ctrl_bf4    (ctrl_bf4),
        .coeff3_addr (coeff3_addr),
        .coeff4_addr (coeff4_addr),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: k = frame cycle index (0 when idle, 1 in the cycle after start is taken),
    // stop_k = frame cycle in which a RUN stop was taken (-1 if none).
    int k       = 0;
    int stop_k  = -1;
    bit done_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_edge(input bit s, input bit p);
        done_exp = 1'b0;
        if (k == 0) begin
            if (s) k = 1;
        end else if (stop_k < 0 && k < D4 && p) begin
            k = 0;
        end else begin
            if (stop_k < 0 && p) stop_k = k;
            if (stop_k >= 0 && k == stop_k + D4) begin
                k        = 0;
                stop_k   = -1;
                done_exp = 1'b1;
            end else begin
                k++;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        int e3, e4;
        e3 = (k >= D3) ? 1 : 0;
        e4 = (k >= D4) ? 1 : 0;
        check({tag, ".busy"},        busy,        (k > 0) ? 1 : 0);
        check({tag, ".stage3_en"},   stage3_en,   e3);
        check({tag, ".stage4_en"},   stage4_en,   e4);
        check({tag, ".ctrl_bf3"},    ctrl_bf3,    e3 ? ((k - D3) / HALF3) % 2 : 0);
        check({tag, ".ctrl_bf4"},    ctrl_bf4,    e4 ? ((k - D4) / HALF4) % 2 : 0);
        check({tag, ".coeff3_addr"}, coeff3_addr, e3 ? (k - D3) % N : 0);
        check({tag, ".coeff4_addr"}, coeff4_addr, e4 ? (k - D4) % N : 0);
        check({tag, ".frame_done"},  frame_done,  done_exp);
    endtask

    task automatic step(input string tag, input bit s, input bit p);
        @(negedge clk);
        start = s;
        stop  = p;
        @(posedge clk);
        model_edge(s, p);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // No auto-start after reset; lone stop in IDLE does nothing.
        repeat (3) step("idle", 1'b0, 1'b0);
        step("idle_stop", 1'b0, 1'b1);
        step("idle", 1'b0, 1'b0);

        // Nominal frame long enough to wrap coeff3_addr, stop in RUN, start ignored in DRAIN.
        step("frame", 1'b1, 1'b0);
        repeat (70) step("frame", 1'b0, 1'b0);
        step("run_stop", 1'b0, 1'b1);
        step("drain_start", 1'b1, 1'b0);
        step("drain_stop", 1'b0, 1'b1);
        repeat (35) step("drain", 1'b0, 1'b0);

        // start+stop together in IDLE enters FILL; stop at t0+10 aborts.
        step("fill", 1'b1, 1'b1);
        repeat (9) step("fill", 1'b0, 1'b0);
        step("fill_stop", 1'b0, 1'b1);
        repeat (30) step("after_abort", 1'b0, 1'b0);

        // start held high: back-to-back frames, never two in flight.
        for (int i = 0; i < 120; i++) step("held", 1'b1, (i == 40) || (i == 50));

        // Asynchronous reset mid-RUN, between clock edges.
        start = 1'b0;
        stop  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        k        = 0;
        stop_k   = -1;
        done_exp = 1'b0;
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("restart", 1'b1, 1'b0);
        repeat (40) step("restart", 1'b0, 1'b0);
        step("restart_stop", 1'b0, 1'b1);
        repeat (30) step("restart", 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            step("rand", bit'($urandom_range(0, 99) < 25), bit'($urandom_range(0, 99) < 2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
